// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;
  localparam logic [7:0]  HALT_WORD = 8'hFF;

  // Instruction word field positions
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned FA_MSB  = 4;
  localparam int unsigned FA_LSB  = 2;
  localparam int unsigned FB_MSB  = 1;
  localparam int unsigned FB_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] pc;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] inst_opcode(input logic [DATA_W_DEF-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory-read and decode-handshake bundle between fetch and its neighbours.
interface fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output mem_addr,
    input  mem_read_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  mem_addr,
    output mem_read_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Shift-style FIFO: the head entry always sits in slot 0 so the outputs come
// straight from flops. Supports same-cycle push+pop and a full flush.
module fetch_skid_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     ent_q [DEPTH];
  logic [W-1:0]     ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] slot_c;
  logic             valid_q, valid_d;

  // Pop shifts everything down one slot; push lands in the first free slot.
  always_comb begin
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    slot_c  = cnt_q;
    valid_d = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && (cnt_q != '0)) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          ent_d[i] = ent_q[i + 1];
        end
        slot_c = cnt_q - CNT_W'(1);
      end
      if (push && (slot_c < CNT_W'(DEPTH))) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == slot_c) begin
            ent_d[i] = wdata;
          end
        end
        cnt_d = slot_c + CNT_W'(1);
      end else begin
        cnt_d = slot_c;
      end
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  assign valid = valid_q;
  assign head  = ent_q[0];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, redirect, one-deep read pipeline into a skid FIFO.
// Optional halt-word detection is enabled with `define FETCH_HALT_DETECT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           bus,
  output logic              halted
);

  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;

  logic              head_valid;
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]  count_c;
  logic              pop_c;
  logic              push_c;
  logic              halt_hit_c;
  logic              issue_c;
  logic [OCC_W-1:0]  occ_c;

  assign pop_c  = head_valid & bus.inst_ready;
  assign push_c = inflight_q & ~redirect_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit_c = push_c && (bus.mem_read_data == DATA_W'(HALT_WORD));
`else
  assign halt_hit_c = 1'b0;
`endif

  // Occupancy after this edge's pop must leave room for the read about to issue.
  assign occ_c   = OCC_W'(count_c) + OCC_W'(inflight_q) - OCC_W'(pop_c);
  assign issue_c = (state_q == RUN) && !redirect_valid && !halt_hit_c &&
                   (occ_c < OCC_W'(BUF_DEPTH));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    halted_d   = halted_q;
    if (redirect_valid) begin
      state_d  = en ? RUN : IDLE;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else if (halt_hit_c) begin
      state_d  = HALT;
      halted_d = 1'b1;
      pc_d     = req_pc_q + ADDR_W'(1);
    end else begin
      if (state_q != HALT) begin
        state_d = en ? RUN : IDLE;
      end
      if (issue_c) begin
        inflight_d = 1'b1;
        req_pc_d   = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  fetch_skid_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata ({bus.mem_read_data, req_pc_q}),
    .pop   (pop_c),
    .flush (redirect_valid),
    .valid (head_valid),
    .head  (head_entry),
    .count (count_c)
  );

  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head_entry[ENTRY_W-1:ADDR_W];
  assign bus.inst_pc    = head_entry[ADDR_W-1:0];
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// traffic checked against a stream-level model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2;
  localparam logic [7:0]  RPC   = 8'h00;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;

  fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  logic [7:0] mem [256];
  always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stream model: after reset/redirect to P, accepted instructions must be
  // P, P+1, ... (mod 256) with data mem[pc], ending after a halt word if enabled.
  logic [7:0] exp_pc;
  int         quiet;
  int         streak;
  bit         hstop;
  bit         stall_prev;
  logic [7:0] prev_pc, prev_data;

  always @(negedge clk) begin
    logic [7:0] nx;
    nx = exp_pc + 8'd1;
    if (rst) begin
      chk("reset_valid", 32'(bus.inst_valid), 32'd0);
      exp_pc = RPC; quiet = 3; streak = 0; hstop = 0; stall_prev = 0;
    end else begin
      chk("buf_no_overflow", 32'(dut.u_fifo.cnt_q <= 2'(DEPTH)), 32'd1);
      if (quiet > 0) chk("latency_valid_low", 32'(bus.inst_valid), 32'd0);
      if (streak >= 3 && !hstop) chk("throughput_valid", 32'(bus.inst_valid), 32'd1);
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.inst_valid), 32'd1);
        chk("hold_pc", 32'(bus.inst_pc), 32'(prev_pc));
        chk("hold_data", 32'(bus.inst_data), 32'(prev_data));
      end
      if (hstop) begin
        chk("halt_valid_low", 32'(bus.inst_valid), 32'd0);
        chk("halt_flag", 32'(halted), 32'd1);
      end else if (!HALT_EN || (mem[exp_pc] != 8'hFF && mem[nx] != 8'hFF)) begin
        chk("halted_low", 32'(halted), 32'd0);
      end
      // Predict the coming edge from the inputs now applied
      if (quiet > 0) quiet--;
      stall_prev = bus.inst_valid && !bus.inst_ready && !redirect_valid;
      prev_pc    = bus.inst_pc;
      prev_data  = bus.inst_data;
      if (bus.inst_valid && bus.inst_ready) begin
        chk("accept_pc", 32'(bus.inst_pc), 32'(exp_pc));
        chk("accept_data", 32'(bus.inst_data), 32'(mem[exp_pc]));
        if (HALT_EN && mem[exp_pc] == 8'hFF) begin
          chk("accept_halted", 32'(halted), 32'd1);
          hstop = 1;
        end
        exp_pc = exp_pc + 8'd1;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc; quiet = 2; streak = en ? 1 : 0; hstop = 0;
      end else if (!en) begin
        streak = 0;
      end else if (streak < 3) begin
        streak++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic v, input logic [7:0] p, input logic [7:0] d);
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'(v));
    if (v) begin
      chk({name, "_pc"}, 32'(bus.inst_pc), 32'(p));
      chk({name, "_data"}, 32'(bus.inst_data), 32'(d));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
    rst = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    bus.inst_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(RPC));
    chk("rst_inst_data", 32'(bus.inst_data), 32'd0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    tick(); tick();
    rst = 1'b0; en = 1'b1; bus.inst_ready = 1'b1;

    // Streaming and back-pressure
    tick(); lit("e1", 1'b0, 8'h00, 8'h00);
    tick(); lit("e2", 1'b0, 8'h00, 8'h00);
    tick(); lit("e3", 1'b1, 8'h00, 8'h10);
    tick(); lit("e4", 1'b1, 8'h01, 8'h11);
    tick(); lit("e5", 1'b1, 8'h02, 8'h12);
    bus.inst_ready = 1'b0;
    tick(); lit("stall1", 1'b1, 8'h02, 8'h12);
    tick(); lit("stall2", 1'b1, 8'h02, 8'h12);
    tick(); lit("stall3", 1'b1, 8'h02, 8'h12);
    bus.inst_ready = 1'b1;
    tick(); lit("resume3", 1'b1, 8'h03, 8'h13);
    tick(); lit("resume4", 1'b1, 8'h04, 8'h14);
    tick(); lit("resume5", 1'b1, 8'h05, 8'h15);

    // Redirect with one buffered entry and one read in flight
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick(); redirect_valid = 1'b0; lit("redir_flush", 1'b0, 8'h00, 8'h00);
    tick(); lit("redir_issue", 1'b0, 8'h00, 8'h00);
    tick(); lit("redir_first", 1'b1, 8'h40, 8'h50);
    tick(); lit("redir_next", 1'b1, 8'h41, 8'h51);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick(); redirect_valid = 1'b0;
    tick();
    tick(); lit("wrap_fe", 1'b1, 8'hFE, 8'h0E);
    tick(); lit("wrap_ff", 1'b1, 8'hFF, 8'h0F);
    tick(); lit("wrap_00", 1'b1, 8'h00, 8'h10);
    tick(); lit("wrap_01", 1'b1, 8'h01, 8'h11);

    // Async reset between edges
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_rst_mem_addr", 32'(bus.mem_addr), 32'(RPC));
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    tick(); lit("restart_0", 1'b1, 8'h00, 8'h10);
    tick(); lit("restart_1", 1'b1, 8'h01, 8'h11);

    // Halt word at pc 3
    #2 rst = 1'b1;
    mem[3] = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    tick(); lit("halt_pc3", 1'b1, 8'h03, 8'hFF);
    chk("halt_flag_pc3", 32'(halted), 32'(HALT_EN));
    tick();
    if (HALT_EN) lit("halt_stop", 1'b0, 8'h00, 8'h00);
    else         lit("nohalt_pc4", 1'b1, 8'h04, 8'h14);
    chk("halt_flag_after", 32'(halted), 32'(HALT_EN));
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick(); redirect_valid = 1'b0;
    chk("halt_cleared", 32'(halted), 32'd0);
    tick();
    tick(); lit("halt_restart", 1'b1, 8'h00, 8'h10);

    // Random traffic
    #2 rst = 1'b1;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      en             = ($urandom_range(0, 9) != 0);
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rand_rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rand_rst_mem_addr", 32'(bus.mem_addr), 32'(RPC));
      end
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
